// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared state encoding and sizing helper for the sequential square root
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter must be able to hold the value ITER.
  function automatic int cnt_width(input int iter);
    return (iter < 1) ? 1 : $clog2(iter + 1);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one combinational restoring square-root digit step
module sqrt_step #(
  parameter int RLEN = 8
) (
  input  logic [RLEN+1:0] rem,
  input  logic [RLEN-1:0] root,
  input  logic [1:0]      pair,
  output logic [RLEN+1:0] rem_next,
  output logic [RLEN-1:0] root_next
);

  logic [RLEN+3:0] s;
  logic [RLEN+3:0] b;
  logic            c;

  assign s = {rem, pair};
  assign b = {2'b00, root, 2'b01};
  assign c = (s >= b);

  // A successful subtract leaves a remainder <= 2*root, so the low RLEN+2 bits hold it exactly.
  assign rem_next  = c ? (s[RLEN+1:0] - b[RLEN+1:0]) : s[RLEN+1:0];
  assign root_next = {root[RLEN-2:0], c};

endmodule

// File: rtl/sqrt_seq.sv
// rtl/sqrt_seq.sv - sequential integer square root, STEPS root bits per clock, valid/ready handshake
module sqrt_seq
  import sqrt_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN-1:0]   X,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN/2-1:0] Y,
  output logic [LEN/2:0]   R,
  output logic             exact
);

  localparam int RLEN = LEN / 2;
  localparam int ITER = RLEN / STEPS;
  localparam int CW   = cnt_width(ITER);

  state_t          state;
  logic [LEN-1:0]  x_sh;
  logic [RLEN-1:0] root;
  logic [RLEN+1:0] rem;
  logic [CW-1:0]   cnt;

  logic [RLEN+1:0] rem_c  [STEPS+1];
  logic [RLEN-1:0] root_c [STEPS+1];

  assign rem_c[0]  = rem;
  assign root_c[0] = root;

  // Step j consumes the j-th bit-pair below the MSB of the shift register.
  for (genvar j = 0; j < STEPS; j++) begin : g_step
    sqrt_step #(.RLEN(RLEN)) u_step (
      .rem       (rem_c[j]),
      .root      (root_c[j]),
      .pair      (x_sh[LEN-1-2*j -: 2]),
      .rem_next  (rem_c[j+1]),
      .root_next (root_c[j+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Y         <= '0;
      R         <= '0;
      exact     <= 1'b0;
      x_sh      <= '0;
      root      <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_sh     <= X;
            root     <= '0;
            rem      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          x_sh <= x_sh << (2 * STEPS);
          root <= root_c[STEPS];
          rem  <= rem_c[STEPS];
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            Y         <= root_c[STEPS];
            R         <= rem_c[STEPS][RLEN:0];
            exact     <= (rem_c[STEPS] == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sqrt_seq.md
# sqrt_seq

Sequential, parametrised integer square root with a valid/ready handshake. It computes floor(sqrt(X)) and the remainder X − Y² using the restoring digit-by-digit method. STEPS root bits are resolved per clock, so one datapath trades area against latency. It sits in the arithmetic library beside the combinational square-root block and replaces it where LEN is large or a remainder or exactness flag is needed.

## Interface
- LEN, 16: operand width. Must be even and ≥ 4.
- STEPS, 1: root bits resolved per cycle. Must divide RLEN = LEN/2.
- Derived: RLEN = LEN/2; ITER = RLEN/STEPS.

Ports:
- clk  in  1  clock. One clock; all logic rising-edge.
- rst  in  1  reset. Synchronous, active-high.
- in_valid  in  1  operand X is valid.
- in_ready  out  1  block can accept an operand.
- X  in  LEN  radicand, unsigned.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- Y  out  RLEN  floor(sqrt(X)).
- R  out  RLEN+1  X − Y²; always ≤ 2Y.
- exact  out  1  R == 0.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid → latch X, clear root/remainder/counter, go to BUSY.
  - BUSY: perform STEPS restoring steps per cycle, consuming X bit-pairs MSB first. After ITER cycles → DONE.
  - DONE: out_valid=1 and Y/R/exact held stable. On out_ready → IDLE.
- One restoring step:
  - s = {rem, next 2 X bits}; b = {root, 2'b01}.
  - c = (s ≥ b), unsigned compare.
  - root ← {root, c}; rem ← c ? s − b : s.
  - Working remainder is RLEN+2 bits. The final remainder fits in RLEN+1 bits; the top bit is dropped.
- Only one operation in flight. in_valid is ignored outside IDLE. X is sampled only at acceptance.
- in_ready is low in BUSY and DONE, including the IDLE-return cycle's predecessor. No same-cycle DONE→accept.
- Reset at any time, including mid-BUSY or in DONE: state=IDLE next edge, operation discarded.
- Output reset values: in_ready=1, out_valid=0, Y=0, R=0, exact=0.
- Y, R and exact are registered. They are only meaningful while out_valid=1, and are held unchanged through DONE regardless of inputs.

## Timing
- Accept at edge k (in_valid && in_ready).
- Compute edges k+1 … k+ITER. out_valid is high after edge k+ITER.
- Latency from acceptance to out_valid = ITER cycles.
- Result consumed at edge m (out_valid && out_ready): in_ready=1 after edge m.
- Minimum issue interval = ITER + 2 cycles with out_ready tied high.
- Critical path: STEPS chained (RLEN+2)-bit subtract/compare stages.

## Structure
- Package sqrt_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - a function computing the counter width, clog2(ITER+1).
- Sub-module sqrt_step: combinational single restoring step, parametrised by RLEN. Inputs rem, root, bit-pair; outputs rem', root'.
- sqrt_seq instantiates STEPS sqrt_step instances in a generate chain. It also holds the FSM, the X shift register, the root/remainder registers and the iteration counter.

## Test plan
- LEN=16, STEPS=1:
  - X=0 → Y=0, R=0, exact=1; out_valid exactly 8 cycles after acceptance.
  - X=65535 → Y=255, R=510, exact=0.
  - X=144 → Y=12, R=0, exact=1. Then X=145 → Y=12, R=1, exact=0.
- LEN=16, STEPS=2: X=1000 → Y=31, R=39; latency 4 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → Y/R stable and in_ready=0 throughout. New in_valid during BUSY/DONE is ignored.
- Assert rst in BUSY mid-operation → next cycle in_ready=1, out_valid=0, Y=R=0. The next operand X=81 then yields Y=9, R=0.
- LEN=32, STEPS=4, 1000 random X → Y²≤X<(Y+1)², R=X−Y², exact==(R==0).
